// File: rtl/player_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : player_pkg                                                    |
// | Purpose  : Shared types, widths and saturating helpers for player logic. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package player_pkg;

  localparam int POS_W = 12;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } player_state_t;

  // Saturating subtract; the compare is one bit wider so a step past zero cannot wrap.
  function automatic logic [POS_W-1:0] sat_sub(
    input logic [POS_W-1:0] pos,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] lo
  );
    logic [POS_W:0] floor_sum;
    floor_sum = {1'b0, lo} + {1'b0, step};
    if ({1'b0, pos} < floor_sum) return lo;
    return pos - step;
  endfunction

  function automatic logic [POS_W-1:0] sat_add(
    input logic [POS_W-1:0] pos,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] hi
  );
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (sum > {1'b0, hi}) return hi;
    return sum[POS_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_tick_gen                                                |
// | Purpose  : Registered one-cycle pulse on each vsync rising edge.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic r_vsync_q;
  logic r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_q <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_tick    <= vsync & ~r_vsync_q;
    end
  end

  assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/player_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : player_ctrl                                                   |
// | Purpose  : Once-per-frame sprite position update from move/jump levels.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module player_ctrl
  import player_pkg::*;
#(
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 736,
  parameter int X_START     = 368,
  parameter int Y_GROUND    = 500,
  parameter int STEP_X      = 4,
  parameter int JUMP_STEP   = 6,
  parameter int JUMP_FRAMES = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vsync,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             jump,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             airborne,
  output logic             frame_tick
);

  localparam int CNT_W = $clog2(JUMP_FRAMES + 1);

  localparam logic [POS_W-1:0] c_x_min     = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] c_x_max     = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] c_x_start   = POS_W'(X_START);
  localparam logic [POS_W-1:0] c_y_ground  = POS_W'(Y_GROUND);
  localparam logic [POS_W-1:0] c_step_x    = POS_W'(STEP_X);
  localparam logic [POS_W-1:0] c_jump_step = POS_W'(JUMP_STEP);
  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(JUMP_FRAMES - 1);

  logic             w_tick;
  logic             w_update;
  logic [POS_W:0]   w_land_sum;

  player_state_t    r_state;
  logic [POS_W-1:0] r_xpos;
  logic [POS_W-1:0] r_ypos;
  logic [CNT_W-1:0] r_jump_cnt;
  logic             r_jump_armed;
  logic             r_airborne;

  player_state_t    w_state_nx;
  logic [POS_W-1:0] w_x_nx;
  logic [POS_W-1:0] w_y_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_armed_nx;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .frame_tick (w_tick)
  );

  assign w_update   = w_tick & en;
  assign w_land_sum = {1'b0, r_ypos} + {1'b0, c_jump_step};

  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_xpos;
    w_y_nx     = r_ypos;
    w_cnt_nx   = r_jump_cnt;
    w_armed_nx = r_jump_armed | ~jump;

    if (w_update) begin
      if (move_left && !move_right) begin
        w_x_nx = sat_sub(r_xpos, c_step_x, c_x_min);
      end else if (move_right && !move_left) begin
        w_x_nx = sat_add(r_xpos, c_step_x, c_x_max);
      end

      case (r_state)
        GROUND: begin
          w_y_nx = c_y_ground;
          // The launch tick already counts as the first rising frame.
          if (jump && r_jump_armed) begin
            w_armed_nx = 1'b0;
            w_cnt_nx   = '0;
            w_y_nx     = c_y_ground - c_jump_step;
            w_state_nx = (JUMP_FRAMES <= 1) ? FALL : RISE;
          end
        end
        RISE: begin
          w_y_nx   = r_ypos - c_jump_step;
          w_cnt_nx = r_jump_cnt + 1'b1;
          if (w_cnt_nx == c_cnt_last) begin
            w_state_nx = FALL;
          end
        end
        FALL: begin
          if (w_land_sum >= {1'b0, c_y_ground}) begin
            w_y_nx     = c_y_ground;
            w_state_nx = GROUND;
          end else begin
            w_y_nx = w_land_sum[POS_W-1:0];
          end
        end
        default: begin
          w_y_nx     = c_y_ground;
          w_state_nx = GROUND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= GROUND;
      r_xpos       <= c_x_start;
      r_ypos       <= c_y_ground;
      r_jump_cnt   <= '0;
      r_jump_armed <= 1'b1;
      r_airborne   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_xpos       <= w_x_nx;
      r_ypos       <= w_y_nx;
      r_jump_cnt   <= w_cnt_nx;
      r_jump_armed <= w_armed_nx;
      r_airborne   <= (w_state_nx != GROUND);
    end
  end

  assign xpos       = r_xpos;
  assign ypos       = r_ypos;
  assign airborne   = r_airborne;
  assign frame_tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_player_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_player_ctrl                                                |
// | Purpose  : Randomized and directed frames against a jump-arc model.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_player_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        vsync;
  logic        move_left;
  logic        move_right;
  logic        jump;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        airborne;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: position plus frames elapsed since launch (0 = standing).
  int m_x;
  int m_y;
  int m_jf;
  bit m_armed;

  player_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .vsync      (vsync),
    .move_left  (move_left),
    .move_right (move_right),
    .jump       (jump),
    .xpos       (xpos),
    .ypos       (ypos),
    .airborne   (airborne),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_x     = 368;
    m_y     = 500;
    m_jf    = 0;
    m_armed = 1'b1;
  endtask

  function automatic int arc_y(input int jf);
    if (jf == 0)  return 500;
    if (jf <= 20) return 500 - 6 * jf;
    return 380 + 6 * (jf - 20);
  endfunction

  task automatic model_tick(input bit l, input bit r, input bit j, input bit e);
    if (!e) return;
    if (l && !r)      m_x = (m_x - 4 < 0)   ? 0   : m_x - 4;
    else if (r && !l) m_x = (m_x + 4 > 736) ? 736 : m_x + 4;
    if (m_jf == 0) begin
      if (j && m_armed) begin
        m_jf    = 1;
        m_armed = 1'b0;
      end
    end else begin
      m_jf++;
    end
    m_y = arc_y(m_jf);
    if (m_jf > 20 && m_y >= 500) begin
      m_y  = 500;
      m_jf = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"},   int'(xpos),     m_x);
    check({tag, "_y"},   int'(ypos),     m_y);
    check({tag, "_air"}, int'(airborne), (m_jf != 0) ? 1 : 0);
  endtask

  // One vsync pulse with inputs held steady across the frame.
  task automatic run_frame(input bit l, input bit r, input bit j, input bit e, input string tag);
    @(negedge clk);
    move_left  = l;
    move_right = r;
    jump       = j;
    en         = e;
    if (!j) m_armed = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    @(posedge clk); #1;
    check({tag, "_tick_hi"}, int'(frame_tick), 1);
    check({tag, "_x_pre"},   int'(xpos),       m_x);
    check({tag, "_y_pre"},   int'(ypos),       m_y);
    @(posedge clk); #1;
    model_tick(l, r, j, e);
    check({tag, "_tick_lo"}, int'(frame_tick), 0);
    check_outputs(tag);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ticks;
    rst_n      = 1'b0;
    en         = 1'b1;
    vsync      = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    jump       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_x",    int'(xpos),       368);
    check("rst_y",    int'(ypos),       500);
    check("rst_air",  int'(airborne),   0);
    check("rst_tick", int'(frame_tick), 0);
    rst_n = 1'b1;

    repeat (3) run_frame(1'b0, 1'b0, 1'b0, 1'b1, "idle");
    repeat (200) run_frame(1'b0, 1'b1, 1'b0, 1'b1, "right");
    check("right_sat", int'(xpos), 736);
    repeat (200) run_frame(1'b1, 1'b0, 1'b0, 1'b1, "left");
    check("left_sat", int'(xpos), 0);
    repeat (10) run_frame(1'b1, 1'b1, 1'b0, 1'b1, "both");

    // Single jump pulse, then a full arc back to the ground.
    run_frame(1'b0, 1'b0, 1'b1, 1'b1, "jstart");
    check("jstart_y", int'(ypos), 494);
    repeat (45) run_frame(1'b0, 1'b0, 1'b0, 1'b1, "arc");
    check("arc_land", int'(ypos), 500);

    // Jump held past landing must not relaunch.
    repeat (50) run_frame(1'b0, 1'b1, 1'b1, 1'b1, "jheld");
    check("jheld_air", int'(airborne), 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, "jrel");
    run_frame(1'b0, 1'b0, 1'b1, 1'b1, "jagain");
    check("jagain_air", int'(airborne), 1);

    // Freeze mid-rise, then resume the same arc.
    repeat (3) run_frame(1'b1, 1'b0, 1'b0, 1'b1, "prefrz");
    repeat (5) run_frame(1'b1, 1'b0, 1'b0, 1'b0, "frozen");
    repeat (40) run_frame(1'b1, 1'b0, 1'b0, 1'b1, "resume");

    // Asynchronous reset in the middle of a jump.
    run_frame(1'b0, 1'b1, 1'b1, 1'b1, "prerst");
    repeat (4) run_frame(1'b0, 1'b1, 1'b0, 1'b1, "prerst2");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_x",   int'(xpos),     368);
    check("arst_y",   int'(ypos),     500);
    check("arst_air", int'(airborne), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Long vsync high: exactly one tick.
    @(negedge clk);
    move_left = 1'b0; move_right = 1'b1; jump = 1'b0; en = 1'b1;
    m_armed = 1'b1;
    vsync = 1'b1;
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (frame_tick) ticks++;
    end
    model_tick(1'b0, 1'b1, 1'b0, 1'b1);
    check("long_vsync_ticks", ticks, 1);
    check_outputs("long_vsync");
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      run_frame(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                ($urandom % 8) != 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
